// File: rtl/layer_bram_ctrl.sv
// Shared BRAM arbitrated between a PS loader and NUM_LAYERS client layers.
// One layer owns the memory at a time; switching drains in-flight reads first.
module layer_bram_ctrl #(
   parameter  int DATA_WIDTH = 16,
   parameter  int DEPTH      = 1024,
   parameter  int NUM_LAYERS = 2,
   parameter  int RD_LATENCY = 1,
   localparam int ADDR_W     = $clog2(DEPTH),
   localparam int LAYER_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             ps_wr_en,
   input  logic [ADDR_W-1:0]                ps_wr_addr,
   input  logic [DATA_WIDTH-1:0]            ps_wr_data,
   input  logic                             ps_load_done,
   input  logic                             layer_req_valid,
   input  logic [LAYER_W-1:0]               layer_req,
   input  logic [NUM_LAYERS-1:0]            wr_en,
   input  logic [NUM_LAYERS*ADDR_W-1:0]     wr_addr,
   input  logic [NUM_LAYERS*DATA_WIDTH-1:0] wr_data,
   input  logic [NUM_LAYERS-1:0]            rd_en,
   input  logic [NUM_LAYERS*ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0]            rd_data,
   output logic                             rd_valid,
   output logic [LAYER_W-1:0]               rd_layer,
   output logic [LAYER_W-1:0]               layer_sel,
   output logic                             mem_ready,
   output logic                             switch_busy,
   output logic [7:0]                       drop_cnt
);

   localparam int IF_W = $clog2(RD_LATENCY + 1) + 1;

   typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_DRAIN, ST_SWITCH} state_e;

   state_e                 state_q;
   logic [LAYER_W-1:0]     layer_sel_q, target_q;
   logic                   mem_ready_q, switch_busy_q;
   logic [7:0]             drop_q;
   logic [IF_W-1:0]        inflight_q;

   logic [ADDR_W-1:0]      wr_addr_a [NUM_LAYERS];
   logic [DATA_WIDTH-1:0]  wr_data_a [NUM_LAYERS];
   logic [ADDR_W-1:0]      rd_addr_a [NUM_LAYERS];

   logic [DATA_WIDTH-1:0]  mem [DEPTH];

   logic [DATA_WIDTH-1:0]  dat_q [RD_LATENCY];
   logic [LAYER_W-1:0]     lay_q [RD_LATENCY];
   logic [RD_LATENCY-1:0]  vld_q;

   logic                   ps_acc, lw_acc, lr_acc, reject, req_ok;
   logic [ADDR_W-1:0]      sel_waddr, sel_raddr, mem_waddr;
   logic [DATA_WIDTH-1:0]  sel_wdata, mem_wdata;

   generate
      for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_unpack
         assign wr_addr_a[gi] = wr_addr[gi*ADDR_W +: ADDR_W];
         assign wr_data_a[gi] = wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
         assign rd_addr_a[gi] = rd_addr[gi*ADDR_W +: ADDR_W];
      end
   endgenerate

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < (ADDR_W+1)'(DEPTH);
   endfunction

   assign sel_waddr = wr_addr_a[layer_sel_q];
   assign sel_wdata = wr_data_a[layer_sel_q];
   assign sel_raddr = rd_addr_a[layer_sel_q];

   // A cycle counts once in drop_cnt no matter how many ports were refused.
   always_comb begin
      ps_acc = 1'b0;
      lw_acc = 1'b0;
      lr_acc = 1'b0;
      reject = 1'b0;
      case (state_q)
         ST_LOAD: begin
            if (ps_wr_en) begin
               if (in_range(ps_wr_addr)) ps_acc = 1'b1;
               else                      reject = 1'b1;
            end
            if (|wr_en || |rd_en) reject = 1'b1;
         end
         ST_RUN: begin
            if (ps_wr_en) reject = 1'b1;
            for (int i = 0; i < NUM_LAYERS; i++) begin
               if (i != int'(layer_sel_q) && (wr_en[i] || rd_en[i])) reject = 1'b1;
            end
            if (wr_en[layer_sel_q]) begin
               if (in_range(sel_waddr)) lw_acc = 1'b1;
               else                     reject = 1'b1;
            end
            if (rd_en[layer_sel_q]) begin
               if (in_range(sel_raddr)) lr_acc = 1'b1;
               else                     reject = 1'b1;
            end
         end
         default: begin
            if (ps_wr_en || |wr_en || |rd_en) reject = 1'b1;
         end
      endcase
   end

   assign req_ok = layer_req_valid && (layer_req != layer_sel_q) &&
                   ({1'b0, layer_req} < (LAYER_W+1)'(NUM_LAYERS));

   assign mem_waddr = ps_acc ? ps_wr_addr : sel_waddr;
   assign mem_wdata = ps_acc ? ps_wr_data : sel_wdata;

   always_ff @(posedge clk) begin
      if (ps_acc || lw_acc) mem[mem_waddr] <= mem_wdata;
   end

   // Stage 0 captures the array before a same-edge write lands (read-first).
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         vld_q <= '0;
         for (int k = 0; k < RD_LATENCY; k++) begin
            dat_q[k] <= '0;
            lay_q[k] <= '0;
         end
      end else begin
         vld_q[0] <= lr_acc;
         if (lr_acc) begin
            dat_q[0] <= mem[sel_raddr];
            lay_q[0] <= layer_sel_q;
         end
         for (int k = 1; k < RD_LATENCY; k++) begin
            vld_q[k] <= vld_q[k-1];
            if (vld_q[k-1]) begin
               dat_q[k] <= dat_q[k-1];
               lay_q[k] <= lay_q[k-1];
            end
         end
      end
   end

   assign rd_valid = vld_q[RD_LATENCY-1];
   assign rd_data  = dat_q[RD_LATENCY-1];
   assign rd_layer = lay_q[RD_LATENCY-1];

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q       <= ST_LOAD;
         layer_sel_q   <= '0;
         target_q      <= '0;
         mem_ready_q   <= 1'b0;
         switch_busy_q <= 1'b0;
         drop_q        <= '0;
         inflight_q    <= '0;
      end else begin
         if (reject && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
         case ({lr_acc, rd_valid})
            2'b10:   inflight_q <= inflight_q + 1'b1;
            2'b01:   inflight_q <= inflight_q - 1'b1;
            default: inflight_q <= inflight_q;
         endcase
         case (state_q)
            ST_LOAD: begin
               if (ps_load_done) begin
                  state_q     <= ST_RUN;
                  mem_ready_q <= 1'b1;
               end
            end
            ST_RUN: begin
               if (req_ok) begin
                  target_q      <= layer_req;
                  switch_busy_q <= 1'b1;
                  state_q       <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (inflight_q == '0) state_q <= ST_SWITCH;
            end
            default: begin
               layer_sel_q   <= target_q;
               switch_busy_q <= 1'b0;
               state_q       <= ST_RUN;
            end
         endcase
      end
   end

   assign layer_sel   = layer_sel_q;
   assign mem_ready   = mem_ready_q;
   assign switch_busy = switch_busy_q;
   assign drop_cnt    = drop_q;

endmodule

// File: doc/layer_bram_ctrl.md
LAYER_BRAM_CTRL -- requirements
Module: layer_bram_ctrl

Interface
REQ-001 SHALL take parameter DATA_WIDTH, default 16: BRAM word width.
REQ-002 SHALL take parameter DEPTH, default 1024: BRAM words; ADDR_W = $clog2(DEPTH).
REQ-003 SHALL take parameter NUM_LAYERS, default 2, legal 1..8: client layer count; LAYER_W = max(1, $clog2(NUM_LAYERS)).
REQ-004 SHALL take parameter RD_LATENCY, default 1, legal 1..3: cycles from read accept to rd_valid.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst_n  in  1  asynchronous reset, active-high.
REQ-008 ps_wr_en / ps_wr_addr / ps_wr_data  in  1 / ADDR_W / DATA_WIDTH  PS load write port.
REQ-009 ps_load_done  in  1  one-cycle pulse marking end of PS load.
REQ-010 layer_req_valid / layer_req  in  1 / LAYER_W  request to change the active layer.
REQ-011 wr_en / wr_addr / wr_data  in  NUM_LAYERS / NUM_LAYERS*ADDR_W / NUM_LAYERS*DATA_WIDTH  per-layer write ports, flattened; layer i in slice i.
REQ-012 rd_en / rd_addr  in  NUM_LAYERS / NUM_LAYERS*ADDR_W  per-layer read ports, flattened.
REQ-013 rd_data / rd_valid / rd_layer  out  DATA_WIDTH / 1 / LAYER_W  read return, valid strobe, originating layer.
REQ-014 layer_sel  out  LAYER_W  currently active layer.
REQ-015 mem_ready / switch_busy  out  1 / 1  PS load complete / layer switch pending.
REQ-016 drop_cnt  out  8  saturating count of rejected accesses.

Function
REQ-017 SHALL implement FSM states LOAD, RUN, DRAIN, SWITCH; reset state LOAD.
REQ-018 LOAD: only ps_wr_en writes accepted; layer reads/writes rejected; ps_load_done -> RUN next cycle, mem_ready = 1 from then on.
REQ-019 RUN: only the layer_sel write/read ports are serviced; ps_wr_en and other layers' wr_en/rd_en are rejected.
REQ-020 A rejected access SHALL increment drop_cnt by one per cycle (not per port), saturating at 255.
REQ-021 An access with address >= DEPTH SHALL be rejected and counted per REQ-020.
REQ-022 RUN + layer_req_valid with layer_req != layer_sel and layer_req < NUM_LAYERS -> latch target, switch_busy = 1, go to DRAIN; all other requests are ignored and not counted.
REQ-023 DRAIN: new reads and writes rejected; stays until in-flight read count = 0, then SWITCH.
REQ-024 SWITCH: one cycle; layer_sel <= latched target; switch_busy = 0 on the following cycle; -> RUN.
REQ-025 layer_req_valid outside RUN SHALL be ignored.
REQ-026 An accepted write SHALL update memory at the clock edge it is sampled.
REQ-027 An accepted read SHALL produce rd_valid = 1, rd_data, rd_layer exactly RD_LATENCY cycles later; one read per cycle sustained.
REQ-028 Read and write to the same address in the same cycle SHALL return the old data (read-first).
REQ-029 rd_data SHALL hold its last value when rd_valid = 0.
REQ-030 In-flight counter width $clog2(RD_LATENCY+1)+1; increment on accept, decrement on rd_valid, both in the same cycle -> unchanged.
REQ-031 ps_load_done in RUN/DRAIN/SWITCH SHALL be ignored.

Reset
REQ-032 rst_n = 1 SHALL asynchronously force: state LOAD, layer_sel 0, mem_ready 0, switch_busy 0, rd_valid 0, rd_data 0, rd_layer 0, drop_cnt 0, in-flight count 0, read pipeline cleared.
REQ-033 Memory contents SHALL NOT be cleared by reset.
REQ-034 Reset mid-read SHALL suppress the pending rd_valid; no rd_valid for 2 cycles after reset deassertion.

Verification
REQ-035 PS load: write addr 5 = 0x1234, pulse ps_load_done, layer 0 reads addr 5 -> rd_valid after RD_LATENCY, rd_data 0x1234, rd_layer 0, mem_ready 1.
REQ-036 Gating: in LOAD, layer 0 wr_en addr 3 -> memory unchanged, drop_cnt 1; in RUN, layer 1 rd_en while layer_sel 0 -> no rd_valid, drop_cnt 2.
REQ-037 Switch with reads in flight (RD_LATENCY 3): reads on 3 consecutive cycles, then layer_req 1 -> 3 rd_valid pulses, layer_sel 1 only after last, switch_busy high throughout.
REQ-038 Collision: addr 9 = 0xAAAA, same-cycle write 0xBBBB + read addr 9 -> rd_data 0xAAAA; next read -> 0xBBBB.
REQ-039 Saturation/boundary: 300 rejected cycles -> drop_cnt 255; read addr DEPTH -> rejected; layer_req = NUM_LAYERS -> ignored, state stays RUN.
REQ-040 Async reset mid-read: assert rst_n between accept and return -> rd_valid never asserts, all outputs at reset values, stored data intact after re-load.
